// File: rtl/gpio_pkg.sv
// Shared defaults and vector types for the GPIO input conditioning path.
package gpio_pkg;
  localparam int N_BTN_DEFAULT           = 4;
  localparam int N_SW_DEFAULT            = 16;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

  typedef logic [N_BTN_DEFAULT-1:0] btn_vec_t;
  typedef logic [N_SW_DEFAULT-1:0]  sw_vec_t;
endpackage

// File: rtl/debounce_bit.sv
// One channel: 2-flop synchroniser followed by a counter debouncer with
// registered rise/fall pulses aligned to the first cycle of the new level.
module debounce_bit
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_reg, s2_reg;
  logic          level_reg, rise_reg, fall_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_reg    <= 1'b0;
      s2_reg    <= 1'b0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      s1_reg   <= raw;
      s2_reg   <= s1_reg;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      // Any return to the accepted level restarts the stability count
      if (s2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_MAX) begin
        level_reg <= s2_reg;
        rise_reg  <= s2_reg;
        fall_reg  <= ~s2_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign level = level_reg;
  assign rise  = rise_reg;
  assign fall  = fall_reg;
endmodule

// File: rtl/gpio_input_conditioner.sv
// Debounces board buttons and switches; adds press/release pulses, sticky
// button event flags and a switch change pulse. Optional BTN_REPEAT_EN adds auto-repeat.
module gpio_input_conditioner
  import gpio_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEFAULT,
  parameter int N_SW            = N_SW_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_SW-1:0]  sw_raw,
  input  logic [N_BTN-1:0] event_clr,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_event,
  output logic [N_SW-1:0]  sw_level,
  output logic             sw_changed
);
  logic [N_BTN-1:0] btn_rise;
  logic [N_BTN-1:0] btn_rep_pulse;
  logic [N_SW-1:0]  sw_rise, sw_fall;
  logic [N_BTN-1:0] event_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_btn
      debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_raw[gi]),
        .level (btn_level[gi]),
        .rise  (btn_rise[gi]),
        .fall  (btn_release[gi])
      );
    end

    for (gi = 0; gi < N_SW; gi++) begin : g_sw
      debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk   (clk),
        .reset (reset),
        .raw   (sw_raw[gi]),
        .level (sw_level[gi]),
        .rise  (sw_rise[gi]),
        .fall  (sw_fall[gi])
      );
    end
  endgenerate

`ifdef BTN_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(RPT_MAX + 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_rpt
      logic [RW-1:0] rpt_cnt_reg;
      logic          in_period_reg;
      logic          rpt_pulse_reg;

      // First interval is REPEAT_DELAY from the press, then REPEAT_PERIOD apart
      always_ff @(posedge clk) begin
        if (reset || !btn_level[gi]) begin
          rpt_cnt_reg   <= '0;
          in_period_reg <= 1'b0;
          rpt_pulse_reg <= 1'b0;
        end else begin
          rpt_pulse_reg <= 1'b0;
          if (rpt_cnt_reg == (in_period_reg ? PER_LAST : DLY_LAST)) begin
            rpt_pulse_reg <= 1'b1;
            rpt_cnt_reg   <= '0;
            in_period_reg <= 1'b1;
          end else begin
            rpt_cnt_reg <= rpt_cnt_reg + 1'b1;
          end
        end
      end

      assign btn_rep_pulse[gi] = rpt_pulse_reg;
    end
  endgenerate
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign btn_rep_pulse     = '0;
`endif

  assign btn_press = btn_rise | btn_rep_pulse;

  // A press arriving together with a clear keeps the flag set
  always_ff @(posedge clk) begin
    if (reset) begin
      event_reg <= '0;
    end else begin
      event_reg <= (event_reg & ~event_clr) | btn_press;
    end
  end

  assign btn_event  = event_reg;
  assign sw_changed = |(sw_rise | sw_fall);
endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed bench for gpio_input_conditioner with DEBOUNCE_CYCLES=4; repeat
// expectations follow BTN_REPEAT_EN.
module tb_gpio_input_conditioner;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  btn_raw, event_clr;
  logic [15:0] sw_raw;
  logic [3:0]  btn_level, btn_press, btn_release, btn_event;
  logic [15:0] sw_level;
  logic        sw_changed;

  int total  = 0;
  int passed = 0;

  gpio_input_conditioner #(
    .N_BTN(4), .N_SW(16), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .sw_raw      (sw_raw),
    .event_clr   (event_clr),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_event   (btn_event),
    .sw_level    (sw_level),
    .sw_changed  (sw_changed)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic logic exp_press(input int off);
`ifdef BTN_REPEAT_EN
    return (off == 0) || (off >= 20 && ((off - 20) % 8) == 0);
`else
    return off == 0;
`endif
  endfunction

  initial begin
    // Reset with all inputs high
    reset = 1'b1; btn_raw = 4'hF; sw_raw = 16'hFFFF; event_clr = 4'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_outputs", {btn_level, btn_press, btn_release, btn_event, sw_level, sw_changed},
          32'h0);
    end
    $display("reset held 3 cycles");

    // Switches held high through reset appear DEBOUNCE_CYCLES+2 edges later
    reset = 1'b0; btn_raw = 4'h0;
    ticks(5);
    chk("sw_thru_rst_early", sw_level, 16'h0000);
    tick();
    chk("sw_thru_rst_level", sw_level, 16'hFFFF);
    chk("sw_thru_rst_chg", sw_changed, 1'b1);
    tick();
    chk("sw_thru_rst_chg_end", sw_changed, 1'b0);
    sw_raw = 16'h0000;
    ticks(5);
    chk("sw_fall_early", sw_level, 16'hFFFF);
    tick();
    chk("sw_fall_level", sw_level, 16'h0000);
    chk("sw_fall_chg", sw_changed, 1'b1);
    $display("switch through reset and back to 0");

    // Button 0 press latency
    btn_raw = 4'h1;
    ticks(5);
    chk("btn0_early", btn_level[0], 1'b0);
    tick();
    chk("btn0_level", btn_level[0], 1'b1);
    chk("btn0_press", btn_press, 4'h1);
    tick();
    chk("btn0_press_end", btn_press, 4'h0);
    chk("btn0_event", btn_event, 4'h1);
    $display("button 0 press");

    // Button 1 glitch of 3 cycles is rejected
    btn_raw = 4'h3;
    ticks(3);
    btn_raw = 4'h1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("btn1_glitch", {btn_level[1], btn_press[1], btn_event[1]}, 3'b000);
    end
    $display("button 1 glitch");

    // Release and clear alone
    btn_raw = 4'h0;
    ticks(5);
    chk("btn0_rel_early", btn_level[0], 1'b1);
    tick();
    chk("btn0_rel_level", btn_level[0], 1'b0);
    chk("btn0_release", btn_release, 4'h1);
    tick();
    chk("btn0_release_end", btn_release, 4'h0);
    chk("btn0_event_sticky", btn_event[0], 1'b1);
    event_clr = 4'h1;
    tick();
    event_clr = 4'h0;
    chk("btn0_clear", btn_event, 4'h0);
    $display("button 0 release and clear");

    // Re-press with clear in the press cycle, then hold 50 cycles
    btn_raw = 4'h1;
    ticks(6);
    for (int off = 0; off <= 50; off++) begin
      chk($sformatf("btn0_press_t+%0d", off), btn_press[0], exp_press(off));
      if (off == 0) event_clr = 4'h1;
      tick();
      if (off == 0) begin
        event_clr = 4'h0;
        chk("btn0_set_wins", btn_event[0], 1'b1);
      end
    end
    $display("button 0 held 50 cycles");
    btn_raw = 4'h0;
    ticks(7);
    chk("btn0_released_again", btn_level[0], 1'b0);

    // Multi-bit switch change gives one pulse
    sw_raw = 16'hA5A5;
    ticks(5);
    chk("sw_a5_early", sw_level, 16'h0000);
    tick();
    chk("sw_a5_level", sw_level, 16'hA5A5);
    chk("sw_a5_chg", sw_changed, 1'b1);
    tick();
    chk("sw_a5_chg_end", sw_changed, 1'b0);
    $display("switch 0xA5A5");
    sw_raw = 16'h0000;
    ticks(6);
    chk("sw_back_zero", sw_level, 16'h0000);

    // Reset during debounce discards the partial count
    sw_raw = 16'hA5A5;
    ticks(3);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sw_mid_rst", {sw_level, 15'h0, sw_changed}, 32'h0);
    end
    sw_raw = 16'h0000;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("sw_after_rst", {sw_level, 15'h0, sw_changed}, 32'h0);
    end
    $display("reset mid-debounce");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
